// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: Ethernet RX CRC-32 check, FCS strip and end-of-frame status
module eth_rx_fcs_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_abort,
  output logic       out_vld,
  output logic [7:0] out_data,
  output logic       out_done,
  output logic       out_ok,
  output logic       err_crc,
  output logic       err_runt,
  output logic       err_giant,
  output logic       err_abort
);
  typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;
  localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME);
  state_t state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_nx, dl_q, dl_d;
  logic [10:0] cnt_q, cnt_d, cnt_nx;
  logic [7:0] data_q, data_d;
  logic [4:0] st_q, st_d;
  logic vld_q, vld_d, done_q, done_d;
  logic abort_ev, acc, fin, bad_crc, runt, giant;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  always_comb begin
    abort_ev = in_abort && state_q != IDLE;
    acc = in_vld && !abort_ev;
    fin = acc && in_last;
    crc_nx = crc_byte(crc_q, in_data);
    cnt_nx = cnt_q + {10'd0, cnt_q != 11'h7FF};
    bad_crc = crc_nx != 32'hDEBB20E3;
    runt = cnt_nx < MIN_L;
    giant = cnt_nx > MAX_L;
    vld_d = acc && state_q == PASS;
    data_d = vld_d ? dl_q[31:24] : 8'h0;
    done_d = fin || abort_ev;
    st_d = abort_ev ? 5'b00001 : fin ? {!(bad_crc || runt || giant), bad_crc, runt, giant, 1'b0} : 5'b0;
    state_d = done_d ? IDLE : acc ? ((state_q == PASS || cnt_nx == 11'd4) ? PASS : FILL) : state_q;
    crc_d = done_d ? 32'hFFFFFFFF : acc ? crc_nx : crc_q;
    cnt_d = done_d ? 11'd0 : acc ? cnt_nx : cnt_q;
    // the oldest byte sits in the top lane and leaves once four are held
    dl_d = done_d ? 32'h0 : acc ? {dl_q[23:0], in_data} : dl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q <= 32'hFFFFFFFF;
      cnt_q <= 11'd0;
      dl_q <= 32'h0;
      vld_q <= 1'b0;
      data_q <= 8'h0;
      done_q <= 1'b0;
      st_q <= 5'b0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      dl_q <= dl_d;
      vld_q <= vld_d;
      data_q <= data_d;
      done_q <= done_d;
      st_q <= st_d;
    end
  end
  assign out_vld = vld_q;
  assign out_data = data_q;
  assign out_done = done_q;
  assign {out_ok, err_crc, err_runt, err_giant, err_abort} = st_q;
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: randomized frames against a standard CRC-32 / length model
module tb_eth_rx_fcs_check;
  logic clk = 0, rst = 1, in_vld = 0, in_last = 0, in_abort = 0;
  logic [7:0] in_data = 0;
  logic a_vld, b_vld, a_done, b_done;
  logic [7:0] a_data, b_data;
  logic [4:0] a_st, b_st;
  int checks = 0, errors = 0;
  logic [7:0] frm[$], got[$], gotb[$];
  int gotk[$];
  int done_a, done_b, done_k, rst_nz;
  logic [4:0] st_a, st_b;

  eth_rx_fcs_check dut_a (.clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
    .in_last(in_last), .in_abort(in_abort), .out_vld(a_vld), .out_data(a_data),
    .out_done(a_done), .out_ok(a_st[4]), .err_crc(a_st[3]), .err_runt(a_st[2]),
    .err_giant(a_st[1]), .err_abort(a_st[0]));
  eth_rx_fcs_check #(.MIN_FRAME(13)) dut_b (.clk(clk), .rst(rst), .in_vld(in_vld),
    .in_data(in_data), .in_last(in_last), .in_abort(in_abort), .out_vld(b_vld),
    .out_data(b_data), .out_done(b_done), .out_ok(b_st[4]), .err_crc(b_st[3]),
    .err_runt(b_st[2]), .err_giant(b_st[1]), .err_abort(b_st[0]));

  always #5 clk = ~clk;

  // standard Ethernet CRC-32 of the first n bytes of frm, final value complemented
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction

  // expected {ok, crc, runt, giant, abort} for a completed frm
  function automatic logic [4:0] exp_st(input int mn);
    int n = frm.size();
    logic c_ok = 1'b0;
    logic runt, giant;
    if (n >= 4) c_ok = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == crc32(n - 4);
    runt = n < mn;
    giant = n > 1518;
    return {c_ok && !runt && !giant, !c_ok, runt, giant, 1'b0};
  endfunction

  task automatic build(input int n, input bit good);
    logic [31:0] c;
    frm.delete();
    repeat (n - 4) frm.push_back(8'($urandom));
    c = crc32(n - 4);
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (!good) begin
      int p = int'($urandom_range(n - 1));
      frm[p] ^= 8'(1 << $urandom_range(7));
    end
  endtask

  task automatic observe(input int k);
    if (a_vld) begin got.push_back(a_data); gotk.push_back(k); end
    if (b_vld) gotb.push_back(b_data);
    if (a_done) begin done_a++; st_a = a_st; done_k = k; end
    if (b_done) begin done_b++; st_b = b_st; end
  endtask

  // drives frm; abort_at/rst_at (1-based byte index, 0 = never) cut the frame short
  task automatic play(input int gap, input int abort_at, input int rst_at, input int tail);
    got.delete(); gotb.delete(); gotk.delete();
    done_a = 0; done_b = 0; done_k = 0; rst_nz = 0; st_a = 0; st_b = 0;
    for (int k = 1; k <= frm.size(); k++) begin
      for (int g = 0; g < 8 && int'($urandom_range(99)) < gap; g++) begin
        in_vld = 0; in_data = 8'($urandom);
        @(posedge clk); #1; observe(-1);
      end
      in_vld = 1; in_data = frm[k-1]; in_last = k == frm.size();
      in_abort = k == abort_at; rst = k == rst_at;
      @(posedge clk); #1; observe(k);
      if (k == rst_at) rst_nz = int'({a_vld, a_data, a_done, a_st, b_vld, b_data, b_done, b_st} != 0);
      if (k == abort_at || k == rst_at) break;
    end
    in_vld = 0; in_last = 0; in_abort = 0; rst = 0;
    repeat (tail) begin @(posedge clk); #1; observe(-1); end
  endtask

  // mismatches of both forwarded streams against frm[0..n-1], plus 4-byte latency
  function automatic int pay_err(input int n);
    int e = int'(got.size() != n) + int'(gotb.size() != n);
    for (int i = 0; i < n && i < got.size() && i < gotb.size(); i++)
      e += int'(got[i] !== frm[i]) + int'(gotb[i] !== frm[i]) + int'(gotk[i] != i + 5);
    return e;
  endfunction

  task automatic test_reset;
    rst = 1; in_vld = 1; in_data = 8'hA5; in_last = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({a_vld, a_data, a_done, a_st} !== 0) begin errors++; $display("FAIL reset_a: got %h expected 0", {a_vld, a_data, a_done, a_st}); end
    checks++; if ({b_vld, b_data, b_done, b_st} !== 0) begin errors++; $display("FAIL reset_b: got %h expected 0", {b_vld, b_data, b_done, b_st}); end
    rst = 0; in_vld = 0; in_last = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_known(input bit flip);
    int e;
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    if (flip) frm[4] ^= 8'h01;
    play(0, 0, 0, 2);
    e = pay_err(9);
    checks++; if (e != 0) begin errors++; $display("FAIL known%0d_payload: got %0d mismatches expected 0", flip, e); end
    checks++; if (done_a != 1 || done_k != 13) begin errors++; $display("FAIL known%0d_done: got %0d at byte %0d expected 1 at 13", flip, done_a, done_k); end
    checks++; if (st_a !== (flip ? 5'b01100 : 5'b00100)) begin errors++; $display("FAIL known%0d_st_min64: got %b expected %b", flip, st_a, flip ? 5'b01100 : 5'b00100); end
    checks++; if (done_b != 1 || st_b !== (flip ? 5'b01000 : 5'b10000)) begin errors++; $display("FAIL known%0d_st_min13: got %0d/%b expected 1/%b", flip, done_b, st_b, flip ? 5'b01000 : 5'b10000); end
  endtask

  task automatic test_back_to_back;
    int e;
    for (int f = 0; f < 3; f++) begin
      build(64, 1);
      play(f == 2 ? 30 : 0, 0, 0, f == 2 ? 2 : 0);
      e = pay_err(60);
      checks++; if (e != 0) begin errors++; $display("FAIL b2b%0d_payload: got %0d mismatches expected 0", f, e); end
      checks++; if (done_a != 1 || st_a !== 5'b10000) begin errors++; $display("FAIL b2b%0d_st: got %0d/%b expected 1/10000", f, done_a, st_a); end
    end
  endtask

  task automatic test_random;
    int e, n;
    for (int f = 0; f < 10; f++) begin
      n = int'($urandom_range(5, 90));
      build(n, $urandom_range(2) != 0);
      play(20, 0, 0, int'($urandom_range(1)));
      e = pay_err(n - 4);
      checks++; if (e != 0) begin errors++; $display("FAIL rand%0d_payload: got %0d mismatches expected 0 (len %0d)", f, e, n); end
      checks++; if (done_a != 1 || st_a !== exp_st(64)) begin errors++; $display("FAIL rand%0d_st_min64: got %0d/%b expected 1/%b", f, done_a, st_a, exp_st(64)); end
      checks++; if (done_b != 1 || st_b !== exp_st(13)) begin errors++; $display("FAIL rand%0d_st_min13: got %0d/%b expected 1/%b", f, done_b, st_b, exp_st(13)); end
    end
  endtask

  task automatic test_runt_giant;
    int e;
    frm = '{8'($urandom), 8'($urandom), 8'($urandom)};
    play(0, 0, 0, 2);
    // the residue of a 3-byte frame is not meaningful, so the CRC flag is masked
    checks++; if (got.size() != 0 || gotb.size() != 0) begin errors++; $display("FAIL runt_vld: got %0d bytes expected 0", got.size()); end
    checks++; if (done_a != 1 || (st_a & 5'b10111) !== 5'b00100) begin errors++; $display("FAIL runt_st_min64: got %0d/%b expected 1/0?100", done_a, st_a); end
    checks++; if (done_b != 1 || (st_b & 5'b10111) !== 5'b00100) begin errors++; $display("FAIL runt_st_min13: got %0d/%b expected 1/0?100", done_b, st_b); end
    build(1519, 1);
    play(0, 0, 0, 2);
    e = pay_err(1515);
    checks++; if (e != 0) begin errors++; $display("FAIL giant_payload: got %0d mismatches expected 0", e); end
    checks++; if (done_a != 1 || st_a !== 5'b00010) begin errors++; $display("FAIL giant_st: got %0d/%b expected 1/00010", done_a, st_a); end
    checks++; if (done_b != 1 || st_b !== 5'b00010) begin errors++; $display("FAIL giant_st_min13: got %0d/%b expected 1/00010", done_b, st_b); end
  endtask

  task automatic test_abort;
    int e;
    build(64, 1);
    play(0, 20, 0, 2);
    e = pay_err(15);
    checks++; if (e != 0) begin errors++; $display("FAIL abort_payload: got %0d mismatches expected 0", e); end
    checks++; if (done_a != 1 || done_k != 20 || st_a !== 5'b00001) begin errors++; $display("FAIL abort_st: got %0d@%0d/%b expected 1@20/00001", done_a, done_k, st_a); end
    checks++; if (done_b != 1 || st_b !== 5'b00001) begin errors++; $display("FAIL abort_st_min13: got %0d/%b expected 1/00001", done_b, st_b); end
  endtask

  task automatic test_rst_mid;
    int e;
    build(64, 1);
    play(0, 0, 20, 2);
    checks++; if (done_a + done_b != 0) begin errors++; $display("FAIL rst_done: got %0d strobes expected 0", done_a + done_b); end
    checks++; if (rst_nz != 0) begin errors++; $display("FAIL rst_outputs: got nonzero expected 0"); end
    build(70, 1);
    play(10, 0, 0, 2);
    e = pay_err(66);
    checks++; if (e != 0) begin errors++; $display("FAIL post_rst_payload: got %0d mismatches expected 0", e); end
    checks++; if (done_a != 1 || st_a !== 5'b10000) begin errors++; $display("FAIL post_rst_st: got %0d/%b expected 1/10000", done_a, st_a); end
  endtask

  initial begin
    test_reset;
    test_known(0);
    test_known(1);
    test_back_to_back;
    test_random;
    test_runt_giant;
    test_abort;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
